// File: rtl/bus20_initiator.sv
// 68020-style bus initiator: splits one internal transfer into AS20/DS20 bus cycles,
// terminated by DSACK with dynamic sizing to 32/16/8-bit ports, BERR and a WAIT timeout.
module bus20_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic [23:0] REQ_ADDR,
    input  logic [1:0]  REQ_SIZE,
    input  logic [31:0] REQ_WDATA,
    output logic [31:0] RDATA,
    output logic        ACK,
    output logic        ERR,
    output logic        BUSY,
    output logic [23:0] A,
    output logic [1:0]  SIZ,
    output logic        AS20,
    output logic        DS20,
    output logic        RW20,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    input  logic [31:0] D_IN,
    input  logic [1:0]  DSACK,
    input  logic        BERR
);

    typedef enum logic [2:0] {ST_IDLE, ST_S0, ST_S1, ST_WAIT, ST_S3, ST_DONE} state_t;

    state_t      state_reg;
    logic        rw_reg;
    logic        err_reg;
    logic [23:0] addr_reg;
    logic [2:0]  cnt_reg;
    logic [31:0] wdata_reg;
    logic [31:0] acc_reg;
    logic [7:0]  tmo_reg;

    logic [2:0]  req_bytes;
    logic        req_misaligned;
    logic [2:0]  port_bytes;
    logic [1:0]  port_off;
    logic [2:0]  room;
    logic [2:0]  take;
    logic [2:0]  lane_shift;
    logic [31:0] lane_data;
    logic [31:0] acc_next;

    // Replicate the remaining right-justified operand so every port width sees its bytes.
    function automatic logic [31:0] replicate(input logic [31:0] d, input logic [2:0] n);
        case (n)
            3'd1:    replicate = {4{d[7:0]}};
            3'd2:    replicate = {2{d[15:0]}};
            3'd3:    replicate = {d[23:0], d[23:16]};
            default: replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] byte_mask(input logic [2:0] n);
        case (n)
            3'd1:    byte_mask = 32'h0000_00FF;
            3'd2:    byte_mask = 32'h0000_FFFF;
            3'd3:    byte_mask = 32'h00FF_FFFF;
            default: byte_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    always_comb begin
        case (REQ_SIZE)
            2'd0:    req_bytes = 3'd1;
            2'd1:    req_bytes = 3'd2;
            default: req_bytes = 3'd4;
        endcase
        req_misaligned = (REQ_SIZE == 2'd1 && REQ_ADDR[0]) ||
                         (REQ_SIZE[1] && REQ_ADDR[1:0] != 2'b00);
    end

    // Bytes accepted by the responding port this cycle and where they sit on D.
    always_comb begin
        case (DSACK)
            2'b00: begin port_bytes = 3'd4; port_off = addr_reg[1:0];       end
            2'b01: begin port_bytes = 3'd2; port_off = {1'b0, addr_reg[0]}; end
            default: begin port_bytes = 3'd1; port_off = 2'b00;             end
        endcase
        room       = port_bytes - {1'b0, port_off};
        take       = (cnt_reg < room) ? cnt_reg : room;
        lane_shift = 3'd4 - {1'b0, port_off} - take;
        lane_data  = (D_IN >> {lane_shift, 3'b000}) & byte_mask(take);
        acc_next   = (acc_reg << {take, 3'b000}) | lane_data;
    end

    always_ff @(posedge CLKCPU or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            rw_reg    <= 1'b1;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            wdata_reg <= '0;
            acc_reg   <= '0;
            tmo_reg   <= '0;
            RDATA     <= '0;
            ACK       <= 1'b0;
            ERR       <= 1'b0;
            BUSY      <= 1'b0;
            A         <= '0;
            SIZ       <= 2'b00;
            AS20      <= 1'b1;
            DS20      <= 1'b1;
            RW20      <= 1'b1;
            D_OUT     <= '0;
            D_OE      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (REQ) begin
                        BUSY      <= 1'b1;
                        rw_reg    <= REQ_RW;
                        wdata_reg <= REQ_WDATA;
                        addr_reg  <= REQ_ADDR;
                        acc_reg   <= '0;
                        err_reg   <= 1'b0;
                        if (req_misaligned) begin
                            ACK       <= 1'b1;
                            ERR       <= 1'b1;
                            RDATA     <= '0;
                            state_reg <= ST_DONE;
                        end else begin
                            cnt_reg   <= req_bytes;
                            A         <= REQ_ADDR;
                            SIZ       <= req_bytes[1:0];
                            RW20      <= REQ_RW;
                            D_OE      <= ~REQ_RW;
                            D_OUT     <= REQ_RW ? 32'h0 : replicate(REQ_WDATA, req_bytes);
                            state_reg <= ST_S0;
                        end
                    end
                end
                ST_S0: begin
                    tmo_reg   <= '0;
                    AS20      <= 1'b0;
                    if (rw_reg)
                        DS20 <= 1'b0;
                    state_reg <= ST_S1;
                end
                ST_S1: begin
                    DS20      <= 1'b0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!BERR) begin
                        AS20      <= 1'b1;
                        DS20      <= 1'b1;
                        err_reg   <= 1'b1;
                        state_reg <= ST_S3;
                    end else if (DSACK != 2'b11) begin
                        if (rw_reg)
                            acc_reg <= acc_next;
                        addr_reg  <= addr_reg + {21'd0, take};
                        cnt_reg   <= cnt_reg - take;
                        AS20      <= 1'b1;
                        DS20      <= 1'b1;
                        state_reg <= ST_S3;
                    end else begin
                        tmo_reg <= tmo_reg + 8'd1;
                        if (tmo_reg == 8'(TIMEOUT - 1)) begin
                            AS20      <= 1'b1;
                            DS20      <= 1'b1;
                            err_reg   <= 1'b1;
                            state_reg <= ST_S3;
                        end
                    end
                end
                ST_S3: begin
                    // An errored cycle does not wait for the responder to release DSACK.
                    if (err_reg || DSACK == 2'b11) begin
                        D_OE <= 1'b0;
                        if (!err_reg && cnt_reg != 3'd0) begin
                            A         <= addr_reg;
                            SIZ       <= cnt_reg[1:0];
                            D_OE      <= ~rw_reg;
                            D_OUT     <= rw_reg ? 32'h0 : replicate(wdata_reg, cnt_reg);
                            state_reg <= ST_S0;
                        end else begin
                            ACK       <= 1'b1;
                            ERR       <= err_reg;
                            RDATA     <= (rw_reg && !err_reg) ? acc_reg : 32'h0;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    ACK       <= 1'b0;
                    ERR       <= 1'b0;
                    BUSY      <= 1'b0;
                    RW20      <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
